// File: rtl/commutation_requester_if.sv
// commutation_requester_if: MPC request / commutator drive bundle (rev 1.0)
`default_nettype none

interface commutation_requester_if;
  logic       mpc_valid;
  logic [5:0] mpc_vec;
  logic       i_sign;
  logic       clr_err;
  logic [5:0] vnew;
  logic       dir;
  logic       busy;
  logic       req_acc;
  logic       err_illegal;
  logic       err_overrun;

  modport master (
    output mpc_valid, mpc_vec, i_sign, clr_err,
    input  vnew, dir, busy, req_acc, err_illegal, err_overrun
  );

  modport slave (
    input  mpc_valid, mpc_vec, i_sign, clr_err,
    output vnew, dir, busy, req_acc, err_illegal, err_overrun
  );
endinterface

`default_nettype wire

// File: rtl/commutation_requester.sv
// commutation_requester: validates MPC switch vectors and drives vnew/dir to the four-step commutator (rev 1.0)
// Optional SIGN_FILTER_EN: debounce the synchronized current sign over DEB_LEN samples.
`default_nettype none

module commutation_requester #(
  parameter int         HOLD_CYC = 8,
  parameter int         DEB_LEN  = 4,
  parameter logic [5:0] RST_VEC  = 6'b000011
) (
  input  logic                    clk,
  input  logic                    rst_n,
  commutation_requester_if.slave  bus
);

  localparam int CNT_W = (HOLD_CYC > 2) ? $clog2(HOLD_CYC) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    APPLY = 2'd2
  } state_t;

  // The commutator needs four steps plus margin; the filter needs at least two samples.
  generate
    if (HOLD_CYC < 5 || DEB_LEN < 2) begin : g_param_check
      $error("commutation_requester: HOLD_CYC must be >= 5 and DEB_LEN >= 2");
    end
  endgenerate

  // ---------------------------------------------------------------- sign path
  logic sync_a;
  logic sync_b;
  logic sign_s;

`ifdef SIGN_FILTER_EN
  logic [DEB_LEN-1:0] deb_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_a  <= 1'b0;
      sync_b  <= 1'b0;
      sign_s  <= 1'b0;
      deb_cnt <= '0;
    end else begin
      sync_a <= bus.i_sign;
      sync_b <= sync_a;
      // Count consecutive samples disagreeing with the accepted sign; accept on the DEB_LEN-th.
      if (sync_b == sign_s) begin
        deb_cnt <= '0;
      end else if (deb_cnt >= DEB_LEN'(DEB_LEN - 1)) begin
        sign_s  <= sync_b;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end
  end
`else
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
    end else begin
      sync_a <= bus.i_sign;
      sync_b <= sync_a;
    end
  end

  assign sign_s = sync_b;
`endif

  // ---------------------------------------------------------------- request FSM
  state_t           state_q,       state_d;
  logic [5:0]       vnew_q,        vnew_d;
  logic [5:0]       target_q,      target_d;
  logic [5:0]       pend_q,        pend_d;
  logic             pend_valid_q,  pend_valid_d;
  logic             dir_q,         dir_d;
  logic             req_acc_q,     req_acc_d;
  logic             err_illegal_q, err_illegal_d;
  logic             err_overrun_q, err_overrun_d;
  logic [CNT_W-1:0] cnt_q,         cnt_d;

  logic legal;
  logic fresh;
  logic to_pend;

  assign legal = (bus.mpc_vec == 6'b000011) ||
                 (bus.mpc_vec == 6'b001100) ||
                 (bus.mpc_vec == 6'b110000);

  // A request equal to what is driven or already in flight changes nothing.
  assign fresh   = bus.mpc_valid && legal &&
                   (bus.mpc_vec != vnew_q) && (bus.mpc_vec != target_q);
  assign to_pend = fresh && !(pend_valid_q && (bus.mpc_vec == pend_q));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      vnew_q        <= RST_VEC;
      target_q      <= RST_VEC;
      pend_q        <= RST_VEC;
      pend_valid_q  <= 1'b0;
      dir_q         <= 1'b0;
      req_acc_q     <= 1'b0;
      err_illegal_q <= 1'b0;
      err_overrun_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      vnew_q        <= vnew_d;
      target_q      <= target_d;
      pend_q        <= pend_d;
      pend_valid_q  <= pend_valid_d;
      dir_q         <= dir_d;
      req_acc_q     <= req_acc_d;
      err_illegal_q <= err_illegal_d;
      err_overrun_q <= err_overrun_d;
      cnt_q         <= cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    vnew_d        = vnew_q;
    target_d      = target_q;
    pend_d        = pend_q;
    pend_valid_d  = pend_valid_q;
    dir_d         = dir_q;
    req_acc_d     = 1'b0;
    err_illegal_d = err_illegal_q;
    err_overrun_d = err_overrun_q;
    cnt_d         = cnt_q;

    // Clear first so that a simultaneous new error still sets its flag.
    if (bus.clr_err) begin
      err_illegal_d = 1'b0;
      err_overrun_d = 1'b0;
    end
    if (bus.mpc_valid && !legal) begin
      err_illegal_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (fresh) begin
          req_acc_d = 1'b1;
          target_d  = bus.mpc_vec;
          dir_d     = sign_s;
          state_d   = SETUP;
        end
      end

      SETUP: begin
        vnew_d  = target_q;
        cnt_d   = CNT_W'(HOLD_CYC - 1);
        state_d = APPLY;
        if (to_pend) begin
          if (pend_valid_q) err_overrun_d = 1'b1;
          pend_d       = bus.mpc_vec;
          pend_valid_d = 1'b1;
        end
      end

      APPLY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
          if (to_pend) begin
            if (pend_valid_q) err_overrun_d = 1'b1;
            pend_d       = bus.mpc_vec;
            pend_valid_d = 1'b1;
          end
        end else if (pend_valid_q) begin
          req_acc_d    = 1'b1;
          target_d     = pend_q;
          dir_d        = sign_s;
          state_d      = SETUP;
          pend_valid_d = 1'b0;
          // The entry is consumed this cycle, so a new request refills it without overrun.
          if (fresh && (bus.mpc_vec != pend_q)) begin
            pend_d       = bus.mpc_vec;
            pend_valid_d = 1'b1;
          end
        end else if (fresh) begin
          // Arrives exactly as the hold ends: start it directly rather than losing it.
          req_acc_d = 1'b1;
          target_d  = bus.mpc_vec;
          dir_d     = sign_s;
          state_d   = SETUP;
        end else begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.vnew        = vnew_q;
  assign bus.dir         = dir_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.req_acc     = req_acc_q;
  assign bus.err_illegal = err_illegal_q;
  assign bus.err_overrun = err_overrun_q;

endmodule

`default_nettype wire
